fetch_queue_stage: RTL and testbench

- Parametrised next-generation fetch stage with a DEPTH-entry instruction prefetch queue.
- Talks to a variable-latency instruction memory through a request/grant/response handshake.
- Feeds the decode pipeline register (instruction_D, pc_D, valid_D).
- Handles branch and interrupt redirection, drops stale in-flight responses, and holds the decode register under stall.

---
 rtl/fetch_queue_stage.sv | 159 +++++++++++++++
 tb/tb_fetch_queue_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_stage.sv
// Fetch stage with a DEPTH-entry prefetch queue feeding the decode register; redirect-to-decode 4 cycles.
// Backpressure: requests stop once queued + in-flight + stale fetches reach DEPTH; add_stall holds decode.

module fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: only entries below count are ever read as valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end
endmodule

module fetch_queue_stage #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] NOP      = 32'h68000000,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            add_stall,
  input  logic            isbranchtaken_E,
  input  logic [XLEN-1:0] pc_branch_E,
  input  logic            interrupt,
  input  logic [XLEN-1:0] pc_isr,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instruction_D,
  output logic [XLEN-1:0] pc_D,
  output logic            valid_D
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 2;

  logic [XLEN-1:0]   fetch_pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     discard;
  logic [CW-1:0]     q_count;
  logic              redirect;
  logic [XLEN-1:0]   target;
  logic [SW-1:0]     occupancy;
  logic              accept;
  logic              resp_keep;
  logic              resp_drop;
  logic              q_push;
  logic              q_pop;
  logic [XLEN-1:0]   resp_pc;
  logic [2*XLEN-1:0] q_head;

  assign redirect = interrupt | isbranchtaken_E;
  assign target   = interrupt ? pc_isr : pc_branch_E;

  assign occupancy = SW'(q_count) + SW'(outstanding) + SW'(discard);
  assign imem_req  = !redirect && (occupancy < SW'(DEPTH));
  assign imem_addr = fetch_pc;
  assign accept    = imem_req & imem_gnt;

  assign resp_drop = imem_rvalid && (discard != '0);
  assign resp_keep = imem_rvalid && (discard == '0);
  assign q_push    = resp_keep && !redirect;
  assign q_pop     = !redirect && !add_stall && (q_count != '0);

  // Live requests since the last redirect are consecutive and answered in order,
  // so the oldest one sits outstanding words behind fetch_pc.
  assign resp_pc = fetch_pc - (XLEN'(outstanding) << 2);

  fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (q_push),
    .push_data ({imem_rdata, resp_pc}),
    .pop       (q_pop),
    .pop_data  (q_head),
    .count     (q_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect) begin
      fetch_pc    <= target;
      outstanding <= '0;
      discard     <= discard + outstanding - CW'(imem_rvalid);
    end else begin
      if (accept) fetch_pc <= fetch_pc + XLEN'(4);
      outstanding <= outstanding + CW'(accept) - CW'(resp_keep);
      discard     <= discard - CW'(resp_drop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instruction_D <= NOP;
      pc_D          <= '0;
      valid_D       <= 1'b0;
    end else if (redirect) begin
      instruction_D <= NOP;
      pc_D          <= '0;
      valid_D       <= 1'b0;
    end else if (!add_stall) begin
      if (q_pop) begin
        instruction_D <= q_head[2*XLEN-1:XLEN];
        pc_D          <= q_head[XLEN-1:0];
        valid_D       <= 1'b1;
      end else begin
        instruction_D <= NOP;
        pc_D          <= '0;
        valid_D       <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fetch_queue_stage.sv
// Randomized bench for fetch_queue_stage against a queue-level model of memory, prefetch queue and decode.
module tb_fetch_queue_stage;
  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] NOP      = 32'h68000000;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        add_stall, isbranchtaken_E, interrupt;
  logic [31:0] pc_branch_E, pc_isr;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instruction_D, pc_D;
  logic        valid_D;

  always #5 clk = ~clk;

  fetch_queue_stage #(
    .XLEN(XLEN), .DEPTH(DEPTH), .NOP(NOP), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst(rst), .add_stall(add_stall),
    .isbranchtaken_E(isbranchtaken_E), .pc_branch_E(pc_branch_E),
    .interrupt(interrupt), .pc_isr(pc_isr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instruction_D(instruction_D), .pc_D(pc_D), .valid_D(valid_D)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } req_t;

  req_t        pend[$];
  logic [31:0] mq[$];
  logic [31:0] m_fpc, d_ins, d_pc;
  logic        d_vld;
  int          checks, errors, cyc;
  int          lat_min, lat_max, p_gnt, p_stall, p_br, p_irq;
  bit          fix_tgt;
  logic [31:0] fix_br, fix_isr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A0000 ^ {a[15:0], a[31:16]};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    mq.delete();
    m_fpc = RESET_PC;
    d_ins = NOP;
    d_pc  = 32'h0;
    d_vld = 1'b0;
  endtask

  task automatic idle_inputs();
    add_stall = 0; isbranchtaken_E = 0; interrupt = 0;
    pc_branch_E = 0; pc_isr = 0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
  endtask

  // Called at a falling edge; ends at the next falling edge.
  task automatic do_cycle();
    req_t        e;
    bit          redir, keep;
    logic [31:0] exp_req, p;
    check_val("instruction_D", instruction_D, d_ins);
    check_val("pc_D", pc_D, d_pc);
    check_val("valid_D", 32'(valid_D), 32'(d_vld));

    add_stall       = ($urandom_range(99) < p_stall);
    isbranchtaken_E = ($urandom_range(99) < p_br);
    interrupt       = ($urandom_range(99) < p_irq);
    pc_branch_E     = fix_tgt ? fix_br  : ($urandom & 32'hFFFFFFFC);
    pc_isr          = fix_tgt ? fix_isr : ($urandom & 32'hFFFFFFFC);
    imem_gnt        = ($urandom_range(99) < p_gnt);
    imem_rvalid     = 1'b0;
    imem_rdata      = $urandom;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend[0].addr);
    end
    redir   = interrupt | isbranchtaken_E;
    exp_req = 32'((!redir && (mq.size() + pend.size() < DEPTH)) ? 1 : 0);
    #1;
    check_val("imem_req", 32'(imem_req), exp_req);
    if (imem_req) check_val("imem_addr", imem_addr, m_fpc);

    keep = 0;
    if (imem_rvalid) begin
      e    = pend.pop_front();
      keep = !e.stale && !redir;
    end
    if (redir) begin
      d_ins = NOP; d_pc = 0; d_vld = 0;
    end else if (!add_stall) begin
      if (mq.size() > 0) begin
        p = mq.pop_front();
        d_ins = mem_word(p); d_pc = p; d_vld = 1;
      end else begin
        d_ins = NOP; d_pc = 0; d_vld = 0;
      end
    end
    if (keep) mq.push_back(e.addr);
    if (redir) begin
      mq.delete();
      foreach (pend[i]) pend[i].stale = 1;
      m_fpc = interrupt ? pc_isr : pc_branch_E;
    end else if (imem_req && imem_gnt) begin
      pend.push_back('{m_fpc, cyc + int'($urandom_range(lat_max, lat_min)), 1'b0});
      m_fpc = m_fpc + 32'd4;
    end
    cyc++;
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between edges; released on a falling edge.
  task automatic pulse_reset();
    idle_inputs();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_val("rst_instruction_D", instruction_D, NOP);
    check_val("rst_pc_D", pc_D, 32'h0);
    check_val("rst_valid_D", 32'(valid_D), 32'h0);
    check_val("rst_imem_addr", imem_addr, RESET_PC);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic knobs(input int lmin, input int lmax, input int gnt, input int stl);
    lat_min = lmin; lat_max = lmax; p_gnt = gnt; p_stall = stl;
    p_br = 0; p_irq = 0; fix_tgt = 0;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    idle_inputs();
    rst = 1'b0;
    model_reset();
    knobs(1, 1, 100, 0);
    @(negedge clk);
    check_val("init_instruction_D", instruction_D, NOP);
    check_val("init_valid_D", 32'(valid_D), 32'h0);
    check_val("init_imem_addr", imem_addr, RESET_PC);
    @(negedge clk);
    rst = 1'b1;

    // Streaming from reset with a 1-cycle memory.
    repeat (12) do_cycle();

    // Long stall fills the queue, then release.
    p_stall = 100;
    repeat (10) do_cycle();
    p_stall = 0;
    repeat (8) do_cycle();

    // Branch while responses are in flight on a 3-cycle memory.
    knobs(3, 3, 100, 0);
    repeat (8) do_cycle();
    fix_tgt = 1; fix_br = 32'h100; p_br = 100;
    do_cycle();
    p_br = 0;
    repeat (10) do_cycle();

    // Interrupt and branch together: interrupt target wins.
    fix_isr = 32'h40; fix_br = 32'h200; p_br = 100; p_irq = 100;
    do_cycle();
    p_br = 0; p_irq = 0;
    repeat (10) do_cycle();

    // Address wrap past the top of memory.
    knobs(1, 1, 100, 0);
    fix_tgt = 1; fix_br = 32'hFFFFFFF8; p_br = 100;
    do_cycle();
    p_br = 0;
    repeat (10) do_cycle();

    // Reset mid-fetch.
    pulse_reset();
    repeat (12) do_cycle();

    // Randomized traffic with varied latency, grant, stall and redirect rates.
    for (int r = 0; r < 8; r++) begin
      knobs(1, int'($urandom_range(5, 1)), int'($urandom_range(100, 30)), int'($urandom_range(60, 0)));
      p_br  = int'($urandom_range(10, 0));
      p_irq = int'($urandom_range(5, 0));
      repeat (500) do_cycle();
      pulse_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
